pcpi_byte_seq: RTL
==================

PCPI_BYTE_SEQ -- requirements
Module: pcpi_byte_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge), rst_n (async assert, active low).
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ui_in  in  8  host data/command byte
- uio_in  in  8  [0] in_valid, [1] abort, [2] out_ack, [7:3] unused
- ena  in  1  ignored
- uo_out  out  8  result byte
- uio_out  out  8  [3] in_ready, [4] out_valid, [5] carry flag, [6] zero flag, others 0
- uio_oe  out  8  constant 8'b0111_1000
REQ-003 Parameters SHALL be: NBYTES, default 4, operand width in bytes.

Function
REQ-004 The FSM SHALL have states IDLE, LOAD_A, LOAD_B, EXEC, OUT.
REQ-005 A byte is accepted on a rising edge when in_valid=1 and in_ready=1; in_ready SHALL be 1 in IDLE, LOAD_A, LOAD_B and 0 in EXEC, OUT.
REQ-006 IDLE: accepted byte is the command; op=ui_in[1:0] (00 ADD, 01 SUB, 10 AND, 11 XOR); bits [7:2] ignored; next state LOAD_A.
REQ-007 LOAD_A/LOAD_B: NBYTES bytes each, LSB first, into operand registers A/B; byte counter wraps 3->0 on the last byte and the state advances to LOAD_B/EXEC.
REQ-008 EXEC: one byte per cycle through the byte ALU, LSB first, for NBYTES cycles; carry register is 0 at byte 0 for ADD, 1 for SUB (SUB computes A + ~B + 1); AND/XOR ignore carry.
REQ-009 Latency: if the last B byte is accepted at edge N, result bytes are computed at edges N+1..N+4 and out_valid SHALL be 1 after edge N+4.
REQ-010 Flags SHALL be registered at the end of EXEC: carry = carry-out of the MSB byte (ADD/SUB; SUB carry=1 means no borrow), 0 for AND/XOR; zero = 1 iff all 32 result bits are 0.
REQ-011 OUT: uo_out SHALL show result byte k (k=0 first), out_valid=1; on an edge with out_ack=1, k increments; after byte NBYTES-1 is acked the state returns to IDLE.
REQ-012 With out_ack=0, uo_out, out_valid and flags SHALL hold stable indefinitely.
REQ-013 uo_out SHALL be 0 and out_valid 0 in every state other than OUT; flags SHALL be valid only while out_valid=1 and 0 otherwise.
REQ-014 abort=1 on any edge SHALL force IDLE, clear counters and flags, and take priority over simultaneous in_valid or out_ack.
REQ-015 in_valid in EXEC/OUT and out_ack outside OUT SHALL be ignored.

Reset
REQ-016 On rst_n=0: state IDLE, counters 0, A/B/result/carry/flags 0, uo_out=0, uio_out=0; uio_oe stays 8'b0111_1000.
REQ-017 Reset asserted mid-operation (any state) SHALL discard the transaction; first accepted byte after release is a command.

Structure
REQ-018 A shared package pcpi_seq_pkg SHALL hold the state enum, op codes, NBYTES default and uio bit indices.
REQ-019 One sub-module byte_alu SHALL implement the combinational 8-bit op with carry-in/carry-out; the controller instantiates it once and reuses it each EXEC cycle.

Verification
REQ-020 ADD: cmd 0x00, A=0x00000001, B=0xFFFFFFFF -> bytes 00 00 00 00, carry=1, zero=1, out_valid 4 cycles after last B byte.
REQ-021 SUB: cmd 0x01, A=5, B=7 -> bytes FE FF FF FF, carry=0, zero=0; SUB 7-5 -> 02 00 00 00, carry=1.
REQ-022 XOR: cmd 0x03, A=0x12345678, B=0xFFFF0000 -> bytes 78 56 CB ED, carry=0; cmd byte 0xFC treated as ADD.
REQ-023 Backpressure: hold out_ack=0 for 10 cycles in OUT -> uo_out stays byte 0, out_valid=1; then ack every cycle -> 4 bytes in 4 cycles, IDLE, in_ready=1.
REQ-024 Abort after 2 B bytes with in_valid=1 same cycle -> IDLE, byte not consumed; next full ADD transaction correct.
REQ-025 rst_n pulsed low during EXEC -> all outputs 0 immediately (async), IDLE after release, next transaction correct.

Source files
------------

// File: rtl/pcpi_seq_pkg.sv
// Shared definitions for the byte-serial PCPI sequencer: FSM states, op codes,
// operand width default and uio bit positions.
package pcpi_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_t;

    localparam int NBYTES_DEF = 4;

    localparam int UIO_IN_VALID  = 0;
    localparam int UIO_ABORT     = 1;
    localparam int UIO_OUT_ACK   = 2;
    localparam int UIO_IN_READY  = 3;
    localparam int UIO_OUT_VALID = 4;
    localparam int UIO_CARRY     = 5;
    localparam int UIO_ZERO      = 6;

    localparam logic [7:0] UIO_OE_MASK = 8'b0111_1000;

endpackage

// File: rtl/pcpi_byte_seq_if.sv
// Pin-level bus of the sequencer: host byte in, control strobes, result byte and status out.
// The host drives the master side; the sequencer sits on the slave side.
interface pcpi_byte_seq_if;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic       ena;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ui_in, uio_in, ena,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ui_in, uio_in, ena,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/byte_alu.sv
// Combinational 8-bit ALU slice with carry chaining; SUB is A + ~B + cin.
// Carry-out is forced to 0 for the bitwise ops.
module byte_alu
    import pcpi_seq_pkg::*;
(
    input  op_t        i_op,
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_y,
    output logic       o_cout
);

    logic [8:0] w_sum;

    always_comb begin
        w_sum  = 9'd0;
        o_y    = 8'h00;
        o_cout = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_sum  = {1'b0, i_a} + {1'b0, i_b} + {8'd0, i_cin};
                o_y    = w_sum[7:0];
                o_cout = w_sum[8];
            end
            OP_SUB: begin
                w_sum  = {1'b0, i_a} + {1'b0, ~i_b} + {8'd0, i_cin};
                o_y    = w_sum[7:0];
                o_cout = w_sum[8];
            end
            OP_AND:  o_y = i_a & i_b;
            default: o_y = i_a ^ i_b;
        endcase
    end

endmodule

// File: rtl/pcpi_byte_seq.sv
// Byte-serial ALU sequencer: command byte, NBYTES of A, NBYTES of B (LSB first),
// NBYTES EXEC cycles through one shared byte_alu, then results presented until acked.
module pcpi_byte_seq
    import pcpi_seq_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    pcpi_byte_seq_if.slave  bus
);

    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int W  = NBYTES * 8;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    state_t         r_state;
    op_t            r_op;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_res;
    logic           r_carry;
    logic           r_cflag;
    logic           r_zflag;
    logic           r_in_rdy;

    logic           w_in_vld;
    logic           w_abort;
    logic           w_out_ack;
    logic           w_accept;
    logic           w_out_vld;
    logic [7:0]     w_a_byte;
    logic [7:0]     w_b_byte;
    logic [7:0]     w_alu_y;
    logic           w_alu_cout;
    logic [7:0]     w_out_byte;
    logic [W-1:0]   w_res_nxt;
    logic [7:0]     w_uio_out;
    logic           w_unused;

    assign w_in_vld  = bus.uio_in[UIO_IN_VALID];
    assign w_abort   = bus.uio_in[UIO_ABORT];
    assign w_out_ack = bus.uio_in[UIO_OUT_ACK];
    assign w_accept  = w_in_vld & r_in_rdy;
    assign w_out_vld = (r_state == ST_OUT);
    assign w_unused  = ^{bus.ena, bus.uio_in[7:3]};

    assign w_a_byte   = r_a[{r_cnt, 3'b000} +: 8];
    assign w_b_byte   = r_b[{r_cnt, 3'b000} +: 8];
    assign w_out_byte = r_res[{r_cnt, 3'b000} +: 8];

    byte_alu u_alu (
        .i_op   (r_op),
        .i_a    (w_a_byte),
        .i_b    (w_b_byte),
        .i_cin  (r_carry),
        .o_y    (w_alu_y),
        .o_cout (w_alu_cout)
    );

    // Result with the current EXEC byte merged in, so the zero flag sees all bytes.
    always_comb begin
        w_res_nxt = r_res;
        w_res_nxt[{r_cnt, 3'b000} +: 8] = w_alu_y;
    end

    always_comb begin
        w_uio_out                = 8'h00;
        w_uio_out[UIO_IN_READY]  = r_in_rdy;
        w_uio_out[UIO_OUT_VALID] = w_out_vld;
        w_uio_out[UIO_CARRY]     = r_cflag & w_out_vld;
        w_uio_out[UIO_ZERO]      = r_zflag & w_out_vld;
    end

    assign bus.uo_out  = w_out_vld ? w_out_byte : 8'h00;
    assign bus.uio_out = w_uio_out;
    assign bus.uio_oe  = UIO_OE_MASK;

    // in_ready is registered and held low through reset, so it rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_ADD;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_carry  <= 1'b0;
            r_cflag  <= 1'b0;
            r_zflag  <= 1'b0;
            r_in_rdy <= 1'b0;
        end else if (w_abort) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_cflag  <= 1'b0;
            r_zflag  <= 1'b0;
            r_in_rdy <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_rdy <= 1'b1;
                    if (w_accept) begin
                        r_op    <= op_t'(bus.ui_in[1:0]);
                        r_cnt   <= '0;
                        r_state <= ST_LOAD_A;
                    end
                end
                ST_LOAD_A: begin
                    if (w_accept) begin
                        r_a[{r_cnt, 3'b000} +: 8] <= bus.ui_in;
                        if (r_cnt == LAST) begin
                            r_cnt   <= '0;
                            r_state <= ST_LOAD_B;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (w_accept) begin
                        r_b[{r_cnt, 3'b000} +: 8] <= bus.ui_in;
                        if (r_cnt == LAST) begin
                            r_cnt    <= '0;
                            r_carry  <= (r_op == OP_SUB);
                            r_in_rdy <= 1'b0;
                            r_state  <= ST_EXEC;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    r_res   <= w_res_nxt;
                    r_carry <= w_alu_cout;
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_cflag <= w_alu_cout;
                        r_zflag <= (w_res_nxt == '0);
                        r_state <= ST_OUT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (w_out_ack) begin
                        if (r_cnt == LAST) begin
                            r_cnt    <= '0;
                            r_cflag  <= 1'b0;
                            r_zflag  <= 1'b0;
                            r_in_rdy <= 1'b1;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_cnt    <= '0;
                    r_in_rdy <= 1'b1;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
